// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and defaults for the UART transmit/receive path.
//               parity_e   - parity mode selector (none / odd / even)
//               tx_state_e - transmitter frame states
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  // 100 MHz system clock / 115200 baud
  localparam int c_clks_per_bit_default = 868;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; held at
//               zero while restart is high so the first bit after a restart
//               is always a full period.
// Ports       : clk         in  system clock
//               rst         in  synchronous reset, active-high
//               restart     in  hold/reload counter to 0
//               bit_end     out high in the last cycle of each bit period
//               bit_pre_end out high in the second-to-last cycle of each bit
//                               period (lets a user register a pulse that
//                               lands exactly on the last cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit_default
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_pre  = c_cnt_w'(CLKS_PER_BIT - 2);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign bit_end     = (r_cnt == c_last);
  assign bit_pre_end = (r_cnt == c_pre);

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_drain
// Description : Reader end of a show-ahead TX FIFO. Pops one word per frame
//               and serialises it as a UART frame (start, DATA_BITS LSB
//               first, optional parity, STOP_BITS stop bits). Frames run
//               back-to-back while the FIFO has data and enable is high.
// Ports       : clk        in  system clock
//               rst        in  synchronous reset, active-high
//               enable     in  permits starting a new frame
//               fifo_q     in  FIFO head word (valid when fifo_empty=0)
//               fifo_empty in  FIFO empty flag
//               fifo_ren   out one-cycle pop strobe
//               tx         out serial line, idle high
//               busy       out high from the pop until the last stop bit ends
//               frame_done out pulse in the last cycle of the last stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = c_clks_per_bit_default,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_ren,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int c_bit_w = $clog2(DATA_BITS + 1);
  localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_BITS);
  localparam logic [c_bit_w-1:0] c_stop_last = c_bit_w'(STOP_BITS);
  localparam logic [c_bit_w-1:0] c_one       = c_bit_w'(1);
  localparam bit c_has_parity = (PARITY != int'(PAR_NONE));
  localparam bit c_odd_parity = (PARITY == int'(PAR_ODD));

  tx_state_e            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [c_bit_w-1:0]   r_bit_cnt;
  logic                 r_par_bit;

  logic w_pop;
  logic w_restart;
  logic w_bit_end;
  logic w_bit_pre_end;
  logic w_par_next;
  logic w_last_stop;

  assign w_pop       = enable && !fifo_empty;
  // Counter is parked at zero in IDLE; every later state entry coincides
  // with a bit_end wrap, so each bit starts from a fresh count.
  assign w_restart   = (r_state == IDLE);
  // Parity of the word being latched equals parity of the latched word;
  // computing it here keeps the shift register free to shift.
  assign w_par_next  = c_odd_parity ? ~^fifo_q : ^fifo_q;
  assign w_last_stop = (r_state == STOP) && (r_bit_cnt == c_stop_last);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .rst         (rst),
    .restart     (w_restart),
    .bit_end     (w_bit_end),
    .bit_pre_end (w_bit_pre_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par_bit  <= 1'b0;
      tx         <= 1'b1;
      fifo_ren   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_ren   <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          tx        <= 1'b1;
          busy      <= 1'b0;
          r_bit_cnt <= '0;
          if (w_pop) begin
            fifo_ren  <= 1'b1;
            r_shift   <= fifo_q;
            r_par_bit <= w_par_next;
            tx        <= 1'b0;
            busy      <= 1'b1;
            r_state   <= START;
          end
        end

        START: begin
          if (w_bit_end) begin
            tx        <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= c_one;
            r_state   <= DATA;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == c_data_last) begin
              if (c_has_parity) begin
                tx      <= r_par_bit;
                r_state <= PAR;
              end else begin
                tx        <= 1'b1;
                r_bit_cnt <= c_one;
                r_state   <= STOP;
              end
            end else begin
              tx        <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + c_one;
            end
          end
        end

        PAR: begin
          if (w_bit_end) begin
            tx        <= 1'b1;
            r_bit_cnt <= c_one;
            r_state   <= STOP;
          end
        end

        STOP: begin
          // Registered pulse: set one cycle early so it sits on the last cycle.
          if (w_last_stop && w_bit_pre_end) begin
            frame_done <= 1'b1;
          end
          if (w_bit_end) begin
            if (r_bit_cnt != c_stop_last) begin
              r_bit_cnt <= r_bit_cnt + c_one;
            end else if (w_pop) begin
              // Back-to-back: next start bit follows with no idle gap.
              fifo_ren  <= 1'b1;
              r_shift   <= fifo_q;
              r_par_bit <= w_par_next;
              r_bit_cnt <= '0;
              tx        <= 1'b0;
              r_state   <= START;
            end else begin
              tx        <= 1'b1;
              busy      <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end
          end
        end

        default: begin
          tx        <= 1'b1;
          busy      <= 1'b0;
          r_bit_cnt <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule : uart_tx_fifo_drain
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_drain
// Description : Self-checking bench. Two instances: u_dut0 (no parity, one
//               stop bit) and u_dut1 (even parity, two stop bits), both with
//               CLKS_PER_BIT=4, each fed from a queue-based show-ahead FIFO.
//               Expected frames are built as bit lists from the data byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en0, en1;
  logic [1:0] empty_v;
  logic [7:0] fq0, fq1;
  logic       ren0, ren1, tx0, tx1, busy0, busy1, done0, done1;
  logic [1:0] ren_v, tx_v, busy_v, done_v;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int pops0 = 0;
  int pops1 = 0;
  int n_checks = 0;
  int n_fail = 0;

  assign ren_v  = {ren1, ren0};
  assign tx_v   = {tx1, tx0};
  assign busy_v = {busy1, busy0};
  assign done_v = {done1, done0};

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .enable(en0), .fifo_q(fq0), .fifo_empty(empty_v[0]),
    .fifo_ren(ren0), .tx(tx0), .busy(busy0), .frame_done(done0)
  );

  uart_tx_fifo_drain #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .fifo_q(fq1), .fifo_empty(empty_v[1]),
    .fifo_ren(ren1), .tx(tx1), .busy(busy1), .frame_done(done1)
  );

  // Show-ahead FIFO model: a pop strobe consumes the head at the clock edge.
  always @(posedge clk) begin
    if (ren0) begin
      pops0++;
      if (q0.size() > 0) void'(q0.pop_front());
    end
    if (ren1) begin
      pops1++;
      if (q1.size() > 0) void'(q1.pop_front());
    end
    empty_v <= {(q1.size() == 0), (q0.size() == 0)};
    if (q0.size() > 0) fq0 <= q0[0]; else fq0 <= 8'h00;
    if (q1.size() > 0) fq1 <= q1[0]; else fq1 <= 8'h00;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {tx, busy, frame_done, fifo_ren}
  function automatic logic [7:0] st(input int s);
    return {4'b0000, tx_v[s], busy_v[s], done_v[s], ren_v[s]};
  endfunction

  // A pop must never be issued against an empty FIFO.
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++)
        chk($sformatf("empty_guard%0d", s), {7'b0, ren_v[s] & empty_v[s]}, 8'h00);
    end
  end

  // Waits (bounded) for a start bit unless imm is set, then checks every cycle
  // of the frame for data byte d against a bit list built from the byte.
  task automatic check_frame(input int s, input logic [7:0] d, input bit imm);
    bit bits[$];
    int k;
    int ncyc;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (s == 1) begin
      bits.push_back(($countones(d) % 2) == 1);  // even parity
      bits.push_back(1'b1);
      bits.push_back(1'b1);
    end else begin
      bits.push_back(1'b1);
    end
    k = 0;
    if (!imm) begin
      while (tx_v[s] !== 1'b0 && k < 300) begin
        @(negedge clk);
        k++;
      end
    end
    ncyc = bits.size() * CPB;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("frame%0d_%02h_cyc%0d", s, d, c), st(s),
          {4'b0000, bits[c / CPB], 1'b1, (c == ncyc - 1), (c == 0)});
    end
    @(negedge clk);
  endtask

  initial begin
    int exp0;
    int exp1;
    int k;
    int n;
    logic [7:0] d[3];

    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset0", st(0), 8'h08);
    chk("reset1", st(1), 8'h08);
    rst = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;

    // Empty FIFO with enable high: line stays idle, no pops.
    repeat (50) begin
      @(negedge clk);
      chk("idle_empty0", st(0), 8'h08);
      chk("idle_empty1", st(1), 8'h08);
    end

    // Single byte, no parity.
    q0.push_back(8'hA5);
    check_frame(0, 8'hA5, 1'b0);
    chk("t1_idle", st(0), 8'h08);
    chk("t1_pops", 8'(pops0), 8'd1);

    // Back-to-back: second start bit right after the first frame's stop bit.
    q0.push_back(8'h00);
    q0.push_back(8'hFF);
    check_frame(0, 8'h00, 1'b0);
    check_frame(0, 8'hFF, 1'b1);
    chk("t2_idle", st(0), 8'h08);
    chk("t2_pops", 8'(pops0), 8'd3);

    // Even parity, two stop bits.
    q1.push_back(8'h07);
    check_frame(1, 8'h07, 1'b0);
    chk("t3_idle", st(1), 8'h08);
    chk("t3_pops", 8'(pops1), 8'd1);

    // Reset during DATA bit 3.
    q0.push_back(8'h3C);
    k = 0;
    while (tx0 !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (17) @(negedge clk);
    chk("t4_bit3", st(0), 8'h0C);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_out", st(0), 8'h08);
    q0.push_back(8'hC3);
    repeat (3) @(negedge clk);
    chk("t4_rst_nopop", 8'(pops0), 8'd4);
    rst = 1'b0;
    check_frame(0, 8'hC3, 1'b0);
    chk("t4_idle", st(0), 8'h08);
    chk("t4_pops", 8'(pops0), 8'd5);

    // Enable gating.
    en0 = 1'b0;
    q0.push_back(8'h5A);
    q0.push_back(8'h96);
    repeat (100) begin
      @(negedge clk);
      chk("t5_gated", st(0), 8'h08);
    end
    chk("t5_gated_pops", 8'(pops0), 8'd5);
    en0 = 1'b1;
    fork
      check_frame(0, 8'h5A, 1'b0);
      begin
        repeat (25) @(negedge clk);
        en0 = 1'b0;
      end
    join
    repeat (50) begin
      chk("t5_after_drop", st(0), 8'h08);
      @(negedge clk);
    end
    chk("t5_drop_pops", 8'(pops0), 8'd6);
    en0 = 1'b1;
    check_frame(0, 8'h96, 1'b0);
    chk("t5_idle", st(0), 8'h08);
    exp0 = 7;
    exp1 = 1;

    // Randomized bursts on both configurations.
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 2; s++) begin
        n = int'($urandom_range(1, 3));
        for (int i = 0; i < n; i++) begin
          d[i] = 8'($urandom);
          if (s == 0) q0.push_back(d[i]); else q1.push_back(d[i]);
        end
        for (int i = 0; i < n; i++) check_frame(s, d[i], i > 0);
        chk($sformatf("rand%0d_idle%0d", r, s), st(s), 8'h08);
        if (s == 0) exp0 += n; else exp1 += n;
      end
    end
    chk("rand_pops0", 8'(pops0), 8'(exp0));
    chk("rand_pops1", 8'(pops1), 8'(exp1));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_fifo_drain
`default_nettype wire
